// File: rtl/rv32_pkg.sv
// Shared types for the RV32 instruction prefetch unit.
// Holds the fetch FSM state encoding and the queue entry layout.
package rv32_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN,
        ERR_HOLD
    } prefetch_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } pf_entry_t;

    localparam logic [31:0] PF_STEP = 32'd4;

    function automatic logic [31:0] pf_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/rv32_mod_instr_prefetch_if.sv
// Instruction bus between the prefetcher (master) and memory (slave).
// Single outstanding request, completed by a one-cycle ack or err.
interface rv32_mod_instr_prefetch_if;

    logic        if_instr_req;
    logic [31:0] instr_addr;
    logic        instr_ack;
    logic        instr_err;
    logic [31:0] instr_data_i;

    modport master (
        output if_instr_req,
        output instr_addr,
        input  instr_ack,
        input  instr_err,
        input  instr_data_i
    );

    modport slave (
        input  if_instr_req,
        input  instr_addr,
        output instr_ack,
        output instr_err,
        output instr_data_i
    );

endinterface

// File: rtl/rv32_mod_sync_fifo.sv
// Small synchronous FIFO holding fetched instruction entries.
// Flush wins over push/pop; push when full and pop when empty are dropped.
module rv32_mod_sync_fifo
    import rv32_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = pf_entry_t,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  T              push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output T              head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    T              mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // Pointer and occupancy next-state.
    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = nxt(wr_q);
            if (do_pop)  rd_d = nxt(rd_q);
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents are only observed while occupied.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data_i;
    end

endmodule

// File: rtl/rv32_mod_instr_prefetch.sv
// RV32 instruction prefetcher: fetches ahead into a small queue.
// A bus request is only issued once a queue slot is reserved for it.
module rv32_mod_instr_prefetch
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc,
    output logic        instr_err_o,
    rv32_mod_instr_prefetch_if.master bus
);

    localparam int CW = $clog2(DEPTH + 1);

    prefetch_state_t state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     tgt_q, tgt_d;
    logic            push, pop, flush;
    logic            full, empty;
    logic [CW-1:0]   count;
    pf_entry_t       push_e, head;
    logic            busy, done;
    logic            room_idle, room_req;

    assign busy      = (state_q == REQ) || (state_q == DRAIN);
    assign done      = busy && (bus.instr_ack || bus.instr_err);
    assign pop       = instr_valid && instr_ready;
    assign room_idle = !full || pop;
    assign room_req  = ((count + CW'(1)) < CW'(DEPTH)) || pop;

    assign bus.if_instr_req = busy;
    assign bus.instr_addr   = addr_q;

    assign instr_valid = !empty;
    assign instr_o     = instr_valid ? head.data : '0;
    assign instr_pc    = instr_valid ? head.addr : '0;
    assign instr_err_o = instr_valid && head.err;

    // Fetch FSM: redirect first, then slot reservation and completion.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        tgt_d       = tgt_q;
        push        = 1'b0;
        flush       = 1'b0;
        push_e.addr = addr_q;
        push_e.data = bus.instr_data_i;
        push_e.err  = 1'b0;
        if (redirect) begin
            flush = 1'b1;
            if (busy && !done) begin
                state_d = DRAIN;
                tgt_d   = pf_align(redirect_addr);
            end else begin
                state_d = REQ;
                addr_d  = pf_align(redirect_addr);
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (room_idle) state_d = REQ;
                end
                REQ: begin
                    if (bus.instr_err) begin
                        push        = 1'b1;
                        push_e.data = '0;
                        push_e.err  = 1'b1;
                        state_d     = ERR_HOLD;
                    end else if (bus.instr_ack) begin
                        push   = 1'b1;
                        addr_d = addr_q + PF_STEP;
                        if (!room_req) state_d = IDLE;
                    end
                end
                DRAIN: begin
                    if (done) begin
                        state_d = REQ;
                        addr_d  = tgt_q;
                    end
                end
                ERR_HOLD: state_d = ERR_HOLD;
                default:  state_d = IDLE;
            endcase
        end
    end

    // FSM and fetch address registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= RESET_PC;
            tgt_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tgt_q   <= tgt_d;
        end
    end

    rv32_mod_sync_fifo #(
        .DEPTH (DEPTH),
        .T     (pf_entry_t)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_e),
        .pop_i       (pop),
        .flush_i     (flush),
        .head_o      (head),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty)
    );

endmodule

// File: tb/tb_rv32_mod_instr_prefetch.sv
// Directed bench for rv32_mod_instr_prefetch.
// Second instance with RESET_PC near the top checks address wrap.
module tb_rv32_mod_instr_prefetch;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instr_o;
    logic [31:0] instr_pc;
    logic        instr_err_o;

    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic        w_err;

    int checks   = 0;
    int failures = 0;
    bit auto_ack = 1'b0;
    bit w_bad    = 1'b0;

    logic [31:0] iss_q [$];
    logic [31:0] pc_q  [$];
    logic [31:0] dat_q [$];
    logic [31:0] w_iss [$];
    logic [31:0] w_pcq [$];

    always #5 clk = ~clk;

    rv32_mod_instr_prefetch_if bus ();
    rv32_mod_instr_prefetch_if bus_w ();

    rv32_mod_instr_prefetch #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_o       (instr_o),
        .instr_pc      (instr_pc),
        .instr_err_o   (instr_err_o),
        .bus           (bus)
    );

    rv32_mod_instr_prefetch #(
        .RESET_PC (32'hFFFF_FFF8),
        .DEPTH    (2)
    ) u_dut_w (
        .clk           (clk),
        .reset         (reset),
        .redirect      (1'b0),
        .redirect_addr (32'h0),
        .instr_valid   (w_valid),
        .instr_ready   (1'b1),
        .instr_o       (w_instr),
        .instr_pc      (w_pc),
        .instr_err_o   (w_err),
        .bus           (bus_w)
    );

    // Zero-wait memory for the wrap instance: data word equals its address.
    assign bus_w.instr_ack    = bus_w.if_instr_req;
    assign bus_w.instr_err    = 1'b0;
    assign bus_w.instr_data_i = bus_w.instr_addr;

    // Log the first fetches and deliveries of the wrap instance.
    always @(negedge clk) begin
        if (!reset && bus_w.if_instr_req && w_iss.size() < 3)
            w_iss.push_back(bus_w.instr_addr);
        if (!reset && w_valid && w_pcq.size() < 3)
            w_pcq.push_back(w_pc);
        if (!reset && w_valid && (w_instr != w_pc || w_err))
            w_bad = 1'b1;
    end

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a + 32'h1000_0000;
    endfunction

    function automatic logic [31:0] qat(input logic [31:0] q [$], input int i);
        return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        if (bus.if_instr_req && bus.instr_ack)
            iss_q.push_back(bus.instr_addr);
        if (instr_valid && instr_ready) begin
            pc_q.push_back(instr_pc);
            dat_q.push_back(instr_o);
        end
        @(posedge clk);
        #1;
        if (auto_ack) begin
            bus.instr_ack    = bus.if_instr_req;
            bus.instr_data_i = mem(bus.instr_addr);
        end
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        redirect         = 1'b0;
        redirect_addr    = '0;
        auto_ack         = 1'b0;
        instr_ready      = 1'b0;
        bus.instr_ack    = 1'b0;
        bus.instr_err    = 1'b0;
        bus.instr_data_i = '0;
        @(posedge clk);
        #1;
        chk("rst_req",   32'(bus.if_instr_req), 0);
        chk("rst_addr",  bus.instr_addr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_pc",    instr_pc, 0);
        chk("rst_err",   32'(instr_err_o), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        iss_q.delete();
        pc_q.delete();
        dat_q.delete();
    endtask

    initial begin
        reset            = 1'b1;
        redirect         = 1'b0;
        redirect_addr    = '0;
        instr_ready      = 1'b0;
        bus.instr_ack    = 1'b0;
        bus.instr_err    = 1'b0;
        bus.instr_data_i = '0;

        // Streaming fetch, zero-wait ack, consumer always ready.
        do_reset();
        instr_ready = 1'b1;
        auto_ack    = 1'b1;
        cyc();
        chk("t1_first_req", 32'(bus.if_instr_req), 1);
        chk("t1_first_addr", bus.instr_addr, 32'h0);
        chk("t1_ack_cyc_valid", 32'(instr_valid), 0);
        cyc();
        chk("t1_valid_lat", 32'(instr_valid), 1);
        chk("t1_head_pc", instr_pc, 32'h0);
        repeat (4) cyc();
        chk("t1_n_iss", iss_q.size(), 5);
        chk("t1_n_pop", pc_q.size(), 4);
        for (int i = 0; i < 3; i++) begin
            chk("t1_iss", qat(iss_q, i), 32'(4 * i));
            chk("t1_pc", qat(pc_q, i), 32'(4 * i));
            chk("t1_data", qat(dat_q, i), mem(32'(4 * i)));
        end

        // Consumer stalled: only two requests fit, pop frees one slot.
        do_reset();
        instr_ready = 1'b0;
        auto_ack    = 1'b1;
        repeat (5) cyc();
        chk("t2_n_iss", iss_q.size(), 2);
        chk("t2_iss0", qat(iss_q, 0), 32'h0);
        chk("t2_iss1", qat(iss_q, 1), 32'h4);
        chk("t2_req_off", 32'(bus.if_instr_req), 0);
        chk("t2_head_pc", instr_pc, 32'h0);
        chk("t2_head_data", instr_o, mem(32'h0));
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        chk("t2_req_on", 32'(bus.if_instr_req), 1);
        chk("t2_req_addr", bus.instr_addr, 32'h8);
        chk("t2_head_next", instr_pc, 32'h4);
        cyc();
        chk("t2_req_full", 32'(bus.if_instr_req), 0);

        // Redirect while the fetch of 4 is outstanding.
        do_reset();
        instr_ready = 1'b1;
        cyc();
        bus.instr_ack    = 1'b1;
        bus.instr_data_i = mem(32'h0);
        cyc();
        bus.instr_ack = 1'b0;
        chk("t3_addr4", bus.instr_addr, 32'h4);
        chk("t3_valid0", 32'(instr_valid), 1);
        redirect      = 1'b1;
        redirect_addr = 32'h0000_0102;
        cyc();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            chk("t3_drain_req", 32'(bus.if_instr_req), 1);
            chk("t3_drain_addr", bus.instr_addr, 32'h4);
            chk("t3_drain_valid", 32'(instr_valid), 0);
        end
        bus.instr_ack    = 1'b1;
        bus.instr_data_i = mem(32'h4);
        cyc();
        bus.instr_ack = 1'b0;
        chk("t3_new_req", 32'(bus.if_instr_req), 1);
        chk("t3_new_addr", bus.instr_addr, 32'h100);
        chk("t3_drop_valid", 32'(instr_valid), 0);
        bus.instr_ack    = 1'b1;
        bus.instr_data_i = mem(32'h100);
        cyc();
        bus.instr_ack = 1'b0;
        chk("t3_valid", 32'(instr_valid), 1);
        chk("t3_pc", instr_pc, 32'h100);
        chk("t3_data", instr_o, mem(32'h100));

        // Redirect with coincident ack, then a bus error.
        do_reset();
        instr_ready = 1'b0;
        cyc();
        redirect         = 1'b1;
        redirect_addr    = 32'h20;
        bus.instr_ack    = 1'b1;
        bus.instr_data_i = mem(32'h0);
        cyc();
        redirect      = 1'b0;
        bus.instr_ack = 1'b0;
        chk("t4_req", 32'(bus.if_instr_req), 1);
        chk("t4_addr", bus.instr_addr, 32'h20);
        chk("t4_valid0", 32'(instr_valid), 0);
        bus.instr_err = 1'b1;
        cyc();
        bus.instr_err = 1'b0;
        chk("t4_err_req", 32'(bus.if_instr_req), 0);
        chk("t4_err_valid", 32'(instr_valid), 1);
        chk("t4_err_flag", 32'(instr_err_o), 1);
        chk("t4_err_pc", instr_pc, 32'h20);
        chk("t4_err_data", instr_o, 32'h0);
        repeat (3) cyc();
        chk("t4_hold_req", 32'(bus.if_instr_req), 0);
        redirect      = 1'b1;
        redirect_addr = 32'h40;
        cyc();
        redirect = 1'b0;
        chk("t4_resume_req", 32'(bus.if_instr_req), 1);
        chk("t4_resume_addr", bus.instr_addr, 32'h40);
        chk("t4_resume_valid", 32'(instr_valid), 0);
        bus.instr_ack    = 1'b1;
        bus.instr_data_i = mem(32'h40);
        cyc();
        bus.instr_ack = 1'b0;
        chk("t4_pc", instr_pc, 32'h40);
        chk("t4_ok_err", 32'(instr_err_o), 0);
        chk("t4_data", instr_o, mem(32'h40));

        // Reset mid-transaction with a late ack just after deassertion.
        do_reset();
        instr_ready = 1'b1;
        cyc();
        chk("t5_req", 32'(bus.if_instr_req), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset            = 1'b0;
        bus.instr_ack    = 1'b1;
        bus.instr_data_i = 32'hBAD0_BAD0;
        chk("t5_idle_req", 32'(bus.if_instr_req), 0);
        cyc();
        bus.instr_ack = 1'b0;
        chk("t5_fresh_req", 32'(bus.if_instr_req), 1);
        chk("t5_fresh_addr", bus.instr_addr, 32'h0);
        chk("t5_valid", 32'(instr_valid), 0);
        cyc();
        chk("t5_still_empty", 32'(instr_valid), 0);

        // Second redirect while draining replaces the target.
        do_reset();
        cyc();
        redirect      = 1'b1;
        redirect_addr = 32'h300;
        cyc();
        redirect_addr = 32'h400;
        cyc();
        redirect = 1'b0;
        chk("t6_hold_addr", bus.instr_addr, 32'h0);
        bus.instr_ack    = 1'b1;
        bus.instr_data_i = mem(32'h0);
        cyc();
        bus.instr_ack = 1'b0;
        chk("t6_req", 32'(bus.if_instr_req), 1);
        chk("t6_addr", bus.instr_addr, 32'h400);
        chk("t6_valid", 32'(instr_valid), 0);

        // Wrap instance: fetch and delivery order across 2^32.
        chk("w_iss0", qat(w_iss, 0), 32'hFFFF_FFF8);
        chk("w_iss1", qat(w_iss, 1), 32'hFFFF_FFFC);
        chk("w_iss2", qat(w_iss, 2), 32'h0000_0000);
        chk("w_pc0", qat(w_pcq, 0), 32'hFFFF_FFF8);
        chk("w_pc1", qat(w_pcq, 1), 32'hFFFF_FFFC);
        chk("w_pc2", qat(w_pcq, 2), 32'h0000_0000);
        chk("w_data", 32'(w_bad), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32_mod_instr_prefetch.md
RV32_MOD_INSTR_PREFETCH -- requirements
Module: rv32_mod_instr_prefetch

Interface
REQ-001 Parameter RESET_PC, 32'h00000000, first fetch address after reset.
REQ-002 Parameter DEPTH, 2, instruction queue entries (legal range 2..8).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 redirect  in  1  flush queue and restart fetch at redirect_addr.
REQ-006 redirect_addr  in  32  new fetch address; bits [1:0] ignored.
REQ-007 instr_valid  out  1  queue head holds an instruction.
REQ-008 instr_ready  in  1  consumer takes the head this cycle.
REQ-009 instr_o  out  32  head instruction word.
REQ-010 instr_pc  out  32  word address of the head.
REQ-011 instr_err_o  out  1  head fetch ended in a bus error.
REQ-012 if_instr_req  out  1  bus request.
REQ-013 instr_addr  out  32  bus word address, [1:0] = 0.
REQ-014 instr_ack  in  1  single-cycle completion; instr_data_i valid.
REQ-015 instr_err  in  1  single-cycle error completion.
REQ-016 instr_data_i  in  32  fetched word.

Function
REQ-017 Bus: if_instr_req and instr_addr SHALL be held stable from assertion until the cycle of instr_ack or instr_err; at most one transaction outstanding.
REQ-018 FSM states: IDLE, REQ, DRAIN, ERR_HOLD.
REQ-019 IDLE->REQ when queue count plus outstanding < DEPTH; REQ->IDLE on ack/err with no free slot, else REQ stays asserted back-to-back with fetch address +4.
REQ-020 Fetch address SHALL increment modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-021 On ack, {addr, data, err=0} SHALL be pushed; instr_valid rises the following cycle (1-cycle ack-to-valid latency).
REQ-022 On err, {addr, 32'h0, err=1} SHALL be pushed and FSM enters ERR_HOLD; no further requests until redirect.
REQ-023 Pop occurs when instr_valid && instr_ready; push and pop in the same cycle SHALL both take effect, count unchanged.
REQ-024 A request SHALL never be issued without a reserved free slot, so push-when-full cannot occur.
REQ-025 instr_ready while empty SHALL be ignored.
REQ-026 Redirect (any state, no transaction outstanding): queue cleared next cycle, fetch address = {redirect_addr[31:2],2'b00}, FSM -> REQ.
REQ-027 Redirect while a transaction is outstanding without completion this cycle: FSM -> DRAIN, new address latched, if_instr_req and instr_addr held until ack/err, response discarded, then REQ at latched address.
REQ-028 Redirect in the same cycle as ack/err: response discarded, FSM -> REQ at new address next cycle.
REQ-029 Redirect coinciding with a pop: redirect wins; pop is a don't-care.
REQ-030 Second redirect during DRAIN SHALL overwrite the latched address.
REQ-031 instr_valid SHALL be 0 in the cycle after any redirect.

Reset
REQ-032 Reset asserted: if_instr_req=0, instr_addr=RESET_PC, instr_valid=0, instr_o=0, instr_pc=0, instr_err_o=0, count=0, FSM=IDLE.
REQ-033 Reset mid-transaction SHALL abandon it; a late ack after reset deassertion, before a new request, SHALL be ignored.
REQ-034 First request SHALL assert in the first cycle after reset deassertion.

Structure
REQ-035 Shared package rv32_pkg SHALL hold prefetch_state_t and the queue entry struct {addr[31:0], data[31:0], err}.
REQ-036 Queue SHALL be a sub-module rv32_mod_sync_fifo (parameter DEPTH, entry type, push/pop/flush, count, full/empty).

Verification
REQ-037 Reset, zero-wait ack, ready=1: addresses 0,4,8 issued back-to-back; instr_pc sequence 0,4,8 with matching data.
REQ-038 ready=0, DEPTH=2: exactly two requests (0,4), then if_instr_req=0; one pop -> request for 8 issues next cycle.
REQ-039 Redirect to 32'h00000102 while request to 4 outstanding, ack after 3 cycles: data for 4 dropped, next request 32'h00000100, instr_valid=0 until then.
REQ-040 Error on address 32'h20: head instr_err_o=1, instr_pc=32'h20, no request until redirect to 32'h40, then fetch resumes at 32'h40.
REQ-041 RESET_PC=32'hFFFFFFF8: fetch sequence FFFFFFF8, FFFFFFFC, 00000000.
REQ-042 Reset pulse during outstanding request with ack one cycle after deassertion: ack ignored, queue empty, fresh request at RESET_PC.
